// File: rtl/mc_datapath_exc_pkg.sv
// Shared encodings for the trapping multicycle MIPS datapath.
// Select codes for the controller-driven muxes, branch conditions and exception codes.
package mc_datapath_exc_pkg;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LEZ = 3'd2,
        BR_GTZ = 3'd3,
        BR_LTZ = 3'd4,
        BR_GEZ = 3'd5
    } br_cond_e;

    localparam logic [2:0] PCS_RES    = 3'd0;
    localparam logic [2:0] PCS_ALUOUT = 3'd1;
    localparam logic [2:0] PCS_JUMP   = 3'd2;
    localparam logic [2:0] PCS_RS     = 3'd3;
    localparam logic [2:0] PCS_EPC    = 3'd4;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_LUI = 2'd2;
    localparam logic [1:0] M2R_PC  = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;
    localparam logic [1:0] RD_R0 = 2'd3;

    localparam logic [1:0] SA_RS   = 2'd0;
    localparam logic [1:0] SA_PC   = 2'd1;
    localparam logic [1:0] SA_MDR  = 2'd2;
    localparam logic [1:0] SA_ZERO = 2'd3;

    localparam logic [1:0] SB_RT   = 2'd0;
    localparam logic [1:0] SB_FOUR = 2'd1;
    localparam logic [1:0] SB_IMM  = 2'd2;
    localparam logic [1:0] SB_BR   = 2'd3;

    localparam logic [4:0] EXC_OV = 5'd12;

    // Conditions 6 and 7 never branch.
    function automatic logic br_taken(
        input logic [2:0]  cond,
        input logic        z,
        input logic [31:0] a
    );
        logic res;
        res = 1'b0;
        case (cond)
            BR_EQ:   res = z;
            BR_NE:   res = !z;
            BR_LEZ:  res = a[31] || (a == 32'h0);
            BR_GTZ:  res = !a[31] && (a != 32'h0);
            BR_LTZ:  res = a[31];
            BR_GEZ:  res = !a[31];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU with zero flag and signed overflow flag for add/sub.
module alu (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALU_operation,
    output logic [31:0] res,
    output logic        zero,
    output logic        overflow
);

    logic [31:0] sum;
    logic [31:0] dif;

    assign sum = A + B;
    assign dif = A - B;

    always_comb begin
        res      = 32'h0;
        overflow = 1'b0;
        case (ALU_operation)
            4'h0: res = A & B;
            4'h1: res = A | B;
            4'h2: begin
                res      = sum;
                overflow = (A[31] == B[31]) && (sum[31] != A[31]);
            end
            4'h3: res = A ^ B;
            4'h4: res = ~(A | B);
            4'h5: res = A >> B[4:0];
            4'h6: begin
                res      = dif;
                overflow = (A[31] != B[31]) && (dif[31] != A[31]);
            end
            4'h7: res = {31'h0, $signed(A) < $signed(B)};
            4'h8: res = {31'h0, A < B};
            4'h9: res = A << B[4:0];
            default: res = 32'h0;
        endcase
    end

    assign zero = (res == 32'h0);

endmodule

// File: rtl/mc_regfile.sv
// NREG-entry register file, two async read ports, one sync write port.
// r0 always reads zero; with 16 entries the top address bit is dropped.
module mc_regfile #(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra_a,
    input  logic [4:0]  ra_b,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd_a,
    output logic [31:0] rd_b
);

    localparam int AW = (NREG == 16) ? 4 : 5;

    logic [31:0]   rf_q [NREG];
    logic [AW-1:0] ia;
    logic [AW-1:0] ib;
    logic [AW-1:0] iw;

    assign ia = ra_a[AW-1:0];
    assign ib = ra_b[AW-1:0];
    assign iw = wa[AW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else if (we && (iw != '0)) begin
            rf_q[iw] <= wd;
        end
    end

    assign rd_a = (ia == '0) ? 32'h0 : rf_q[ia];
    assign rd_b = (ib == '0) ? 32'h0 : rf_q[ib];

endmodule

// File: rtl/single_signext.sv
// Immediate extender: sign- or zero-extends a 16-bit field to 32 bits.
module single_signext (
    input  logic        Signext,
    input  logic [15:0] imm_16,
    output logic [31:0] Imm_32
);

    assign Imm_32 = Signext ? {{16{imm_16[15]}}, imm_16} : {16'h0, imm_16};

endmodule

// File: rtl/mc_datapath_exc.sv
// Multicycle MIPS datapath with memory-ready stalls, branch conditions
// and a precise arithmetic-overflow trap (EPC/Cause, eret path).
module mc_datapath_exc
    import mc_datapath_exc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_0180,
    parameter int          NREG     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MIO_ready,
    input  logic [31:0] data2CPU,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic        RegWrite,
    input  logic [1:0]  RegDst,
    input  logic [1:0]  MemtoReg,
    input  logic [1:0]  ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic        Signext,
    input  logic [3:0]  ALU_operation,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic [2:0]  BrCond,
    input  logic [2:0]  PCSource,
    input  logic        OvfCheck,
    output logic [31:0] PC_Current,
    output logic [31:0] Inst_R,
    output logic [31:0] M_addr,
    output logic [31:0] data_out,
    output logic        zero,
    output logic        overflow,
    output logic [31:0] EPC,
    output logic [31:0] Cause,
    output logic        exc_taken
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic        ovf_q, ovf_d;

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_ext;
    logic [31:0] br_off;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        trap;
    logic        reg_we;
    logic        br_ok;
    logic        pc_en;

    single_signext u_ext (
        .Signext (Signext),
        .imm_16  (ir_q[15:0]),
        .Imm_32  (imm_ext)
    );

    mc_regfile #(
        .NREG (NREG)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (reg_we),
        .ra_a  (ir_q[25:21]),
        .ra_b  (ir_q[20:16]),
        .wa    (waddr),
        .wd    (wdata),
        .rd_a  (rs_val),
        .rd_b  (rt_val)
    );

    alu u_alu (
        .A             (alu_a),
        .B             (alu_b),
        .ALU_operation (ALU_operation),
        .res           (alu_res),
        .zero          (zero),
        .overflow      (overflow)
    );

    // Branch offsets are always signed, independent of Signext.
    assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    always_comb begin
        alu_a = 32'h0;
        alu_b = 32'h0;
        case (ALUSrcA)
            SA_RS:   alu_a = rs_val;
            SA_PC:   alu_a = pc_q;
            SA_MDR:  alu_a = mdr_q;
            default: alu_a = 32'h0;
        endcase
        case (ALUSrcB)
            SB_RT:   alu_b = rt_val;
            SB_FOUR: alu_b = 32'd4;
            SB_IMM:  alu_b = imm_ext;
            default: alu_b = br_off;
        endcase
    end

    always_comb begin
        waddr = 5'd0;
        wdata = 32'h0;
        case (RegDst)
            RD_RT:   waddr = ir_q[20:16];
            RD_RD:   waddr = ir_q[15:11];
            RD_RA:   waddr = 5'd31;
            default: waddr = 5'd0;
        endcase
        case (MemtoReg)
            M2R_ALU: wdata = alu_out_q;
            M2R_MDR: wdata = mdr_q;
            M2R_LUI: wdata = {ir_q[15:0], 16'h0};
            default: wdata = pc_q;
        endcase
    end

    always_comb begin
        trap      = RegWrite && (MemtoReg == M2R_ALU) && ovf_q && MIO_ready;
        br_ok     = br_taken(BrCond, zero, rs_val);
        pc_en     = MIO_ready && (PCWrite || (PCWriteCond && br_ok));
        reg_we    = RegWrite && MIO_ready && !trap;
        alu_out_d = alu_res;
        ovf_d     = overflow && OvfCheck;
        mdr_d     = MIO_ready ? data2CPU : mdr_q;
        ir_d      = (IRWrite && MIO_ready) ? data2CPU : ir_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        pc_d      = pc_q;
        // The trap wins over any PC update the controller asks for.
        if (trap) begin
            epc_d   = pc_q - 32'd4;
            cause_d = {25'h0, EXC_OV, 2'b00};
            pc_d    = EXC_VEC;
        end else if (pc_en) begin
            case (PCSource)
                PCS_RES:    pc_d = alu_res;
                PCS_ALUOUT: pc_d = alu_out_q;
                PCS_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                PCS_RS:     pc_d = rs_val;
                PCS_EPC:    pc_d = epc_q;
                default:    pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            mdr_q     <= 32'h0;
            alu_out_q <= 32'h0;
            epc_q     <= 32'h0;
            cause_q   <= 32'h0;
            ovf_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            alu_out_q <= alu_out_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            ovf_q     <= ovf_d;
        end
    end

    assign PC_Current = pc_q;
    assign Inst_R     = ir_q;
    assign M_addr     = IorD ? pc_q : alu_out_q;
    assign data_out   = rt_val;
    assign EPC        = epc_q;
    assign Cause      = cause_q;
    assign exc_taken  = trap && !reset;

endmodule

// File: tb/tb_mc_datapath_exc.sv
// Bench for mc_datapath_exc: directed scenarios plus random control
// sequences, all checked every cycle against an architectural model.
module tb_mc_datapath_exc;

    localparam logic [31:0] RPC  = 32'h0000_3000;
    localparam logic [31:0] EVEC = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        reset, MIO_ready, IorD, IRWrite, RegWrite, Signext;
    logic        PCWrite, PCWriteCond, OvfCheck;
    logic [31:0] data2CPU;
    logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB;
    logic [3:0]  ALU_operation;
    logic [2:0]  BrCond, PCSource;
    logic [31:0] PC_Current, Inst_R, M_addr, data_out, EPC, Cause;
    logic        zero, overflow, exc_taken;

    always #5 clk = ~clk;

    mc_datapath_exc #(
        .RESET_PC (RPC),
        .EXC_VEC  (EVEC),
        .NREG     (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .MIO_ready     (MIO_ready),
        .data2CPU      (data2CPU),
        .IorD          (IorD),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .Signext       (Signext),
        .ALU_operation (ALU_operation),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .BrCond        (BrCond),
        .PCSource      (PCSource),
        .OvfCheck      (OvfCheck),
        .PC_Current    (PC_Current),
        .Inst_R        (Inst_R),
        .M_addr        (M_addr),
        .data_out      (data_out),
        .zero          (zero),
        .overflow      (overflow),
        .EPC           (EPC),
        .Cause         (Cause),
        .exc_taken     (exc_taken)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural state of the model
    logic        m_valid = 1'b0;
    logic [31:0] m_pc, m_ir, m_mdr, m_alu, m_epc, m_cause;
    logic        m_ovf;
    logic [31:0] m_rf [32];

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic        br;
        logic        trap;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  wa;
        logic [31:0] wd;
    } comb_t;

    function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, s;
        logic [31:0] r;
        logic        v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        v  = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin s = sa + sb; r = s[31:0]; v = (s != longint'($signed(r))); end
            4'h3: r = a ^ b;
            4'h4: r = ~(a | b);
            4'h5: r = a >> b[4:0];
            4'h6: begin s = sa - sb; r = s[31:0]; v = (s != longint'($signed(r))); end
            4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h8: r = (a < b) ? 32'd1 : 32'd0;
            4'h9: r = a << b[4:0];
            default: r = 32'h0;
        endcase
        return {v, r};
    endfunction

    function automatic comb_t eval();
        comb_t       c;
        logic [31:0] ext, a, b;
        c.rs = m_rf[m_ir[25:21]];
        c.rt = m_rf[m_ir[20:16]];
        ext  = Signext ? {{16{m_ir[15]}}, m_ir[15:0]} : {16'h0, m_ir[15:0]};
        case (ALUSrcA)
            2'd0: a = c.rs;
            2'd1: a = m_pc;
            2'd2: a = m_mdr;
            default: a = 32'h0;
        endcase
        case (ALUSrcB)
            2'd0: b = c.rt;
            2'd1: b = 32'd4;
            2'd2: b = ext;
            default: b = {{14{m_ir[15]}}, m_ir[15:0], 2'b00};
        endcase
        {c.ovf, c.res} = alu_model(ALU_operation, a, b);
        c.zero = (c.res == 32'h0);
        case (BrCond)
            3'd0: c.br = c.zero;
            3'd1: c.br = !c.zero;
            3'd2: c.br = $signed(c.rs) <= 0;
            3'd3: c.br = $signed(c.rs) > 0;
            3'd4: c.br = $signed(c.rs) < 0;
            3'd5: c.br = $signed(c.rs) >= 0;
            default: c.br = 1'b0;
        endcase
        case (RegDst)
            2'd0: c.wa = m_ir[20:16];
            2'd1: c.wa = m_ir[15:11];
            2'd2: c.wa = 5'd31;
            default: c.wa = 5'd0;
        endcase
        case (MemtoReg)
            2'd0: c.wd = m_alu;
            2'd1: c.wd = m_mdr;
            2'd2: c.wd = {m_ir[15:0], 16'h0};
            default: c.wd = m_pc;
        endcase
        c.trap = RegWrite && (MemtoReg == 2'd0) && m_ovf && MIO_ready;
        return c;
    endfunction

    always @(posedge clk) begin : model_upd
        comb_t c;
        c = eval();
        if (reset) begin
            m_valid <= 1'b1;
            m_pc    <= RPC;
            m_ir    <= 32'h0;
            m_mdr   <= 32'h0;
            m_alu   <= 32'h0;
            m_epc   <= 32'h0;
            m_cause <= 32'h0;
            m_ovf   <= 1'b0;
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'h0;
        end else if (m_valid) begin
            m_alu <= c.res;
            m_ovf <= c.ovf && OvfCheck;
            if (MIO_ready) begin
                m_mdr <= data2CPU;
                if (IRWrite) m_ir <= data2CPU;
                if (c.trap) begin
                    m_epc   <= m_pc - 32'd4;
                    m_cause <= 32'h0000_0030;
                    m_pc    <= EVEC;
                end else begin
                    if (RegWrite && c.wa != 5'd0) m_rf[c.wa] <= c.wd;
                    if (PCWrite || (PCWriteCond && c.br)) begin
                        case (PCSource)
                            3'd0: m_pc <= c.res;
                            3'd1: m_pc <= m_alu;
                            3'd2: m_pc <= {m_pc[31:28], m_ir[25:0], 2'b00};
                            3'd3: m_pc <= c.rs;
                            3'd4: m_pc <= m_epc;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        comb_t c;
        if (m_valid) begin
            c = eval();
            chk("pc", PC_Current, m_pc);
            chk("inst_r", Inst_R, m_ir);
            chk("m_addr", M_addr, IorD ? m_pc : m_alu);
            chk("data_out", data_out, c.rt);
            chk("zero", 32'(zero), 32'(c.zero));
            chk("overflow", 32'(overflow), 32'(c.ovf));
            chk("epc", EPC, m_epc);
            chk("cause", Cause, m_cause);
            chk("exc_taken", 32'(exc_taken), 32'(c.trap && !reset));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        MIO_ready = 1'b1; data2CPU = 32'h0; IorD = 1'b0; IRWrite = 1'b0;
        RegWrite = 1'b0; RegDst = 2'd0; MemtoReg = 2'd0; ALUSrcA = 2'd0;
        ALUSrcB = 2'd0; Signext = 1'b0; ALU_operation = 4'h0; PCWrite = 1'b0;
        PCWriteCond = 1'b0; BrCond = 3'd0; PCSource = 3'd0; OvfCheck = 1'b0;
    endtask

    task automatic load_ir(input logic [31:0] v);
        idle(); data2CPU = v; IRWrite = 1'b1; tick(); idle();
    endtask

    task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
        load_ir({11'h0, r, 16'h0});
        data2CPU = v; tick();
        idle(); RegWrite = 1'b1; MemtoReg = 2'd1; RegDst = 2'd0; tick();
        idle(); #1;
        chk("set_reg", data_out, v);
    endtask

    task automatic add_ovf_cycle();
        idle(); ALUSrcA = 2'd0; ALUSrcB = 2'd0; ALU_operation = 4'h2; OvfCheck = 1'b1;
        tick();
    endtask

    localparam logic [31:0] ADD_INS = {6'h0, 5'd10, 5'd11, 5'd12, 5'd0, 6'h20};

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_pc", PC_Current, 32'h0000_3000);
        chk("rst_ir", Inst_R, 32'h0);
        chk("rst_epc", EPC, 32'h0);
        chk("rst_exc", 32'(exc_taken), 32'h0);

        // Stalled fetch then completion
        idle();
        IRWrite = 1'b1; data2CPU = 32'h2008_0005; MIO_ready = 1'b0;
        PCWrite = 1'b1; PCSource = 3'd0; ALUSrcA = 2'd1; ALUSrcB = 2'd1;
        ALU_operation = 4'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ir", Inst_R, 32'h0);
            chk("stall_pc", PC_Current, 32'h0000_3000);
        end
        MIO_ready = 1'b1;
        tick();
        chk("fetch_ir", Inst_R, 32'h2008_0005);
        chk("fetch_pc", PC_Current, 32'h0000_3004);
        idle();

        // bne not taken, then taken via ALU_Out
        set_reg(5'd5, 32'd5);
        set_reg(5'd6, 32'd5);
        set_reg(5'd7, 32'd6);
        load_ir({6'h05, 5'd5, 5'd6, 16'h0});
        ALU_operation = 4'h6; BrCond = 3'd1; PCWriteCond = 1'b1; PCSource = 3'd0;
        tick(); idle();
        chk("bne_eq", PC_Current, 32'h0000_3004);
        load_ir({6'h05, 5'd5, 5'd7, 16'h0040});
        ALUSrcA = 2'd3; ALUSrcB = 2'd2; ALU_operation = 4'h2;
        tick(); idle();
        ALU_operation = 4'h6; BrCond = 3'd1; PCWriteCond = 1'b1; PCSource = 3'd1;
        tick(); idle();
        chk("bne_ne", PC_Current, 32'h0000_0040);

        // bgtz on negative and positive rs
        set_reg(5'd8, 32'hFFFF_FFFF);
        set_reg(5'd9, 32'd1);
        for (int k = 0; k < 2; k++) begin
            load_ir({6'h07, (k == 0) ? 5'd8 : 5'd9, 5'd0, 16'h0});
            ALUSrcA = 2'd1; ALUSrcB = 2'd1; ALU_operation = 4'h2;
            BrCond = 3'd3; PCWriteCond = 1'b1; PCSource = 3'd0;
            tick(); idle();
            chk("bgtz", PC_Current, (k == 0) ? 32'h40 : 32'h44);
        end

        // Overflow trap at PC=0x104
        set_reg(5'd10, 32'h7FFF_FFFF);
        set_reg(5'd11, 32'd1);
        set_reg(5'd12, 32'h0000_1234);
        load_ir(32'h0000_0104);
        ALUSrcA = 2'd3; ALUSrcB = 2'd2; ALU_operation = 4'h2;
        PCWrite = 1'b1; PCSource = 3'd0;
        tick(); idle();
        chk("set_pc", PC_Current, 32'h0000_0104);
        load_ir(ADD_INS);
        add_ovf_cycle();
        idle(); RegWrite = 1'b1; RegDst = 2'd1; MemtoReg = 2'd0;
        PCWrite = 1'b1; PCSource = 3'd1;
        #1;
        chk("trap_exc", 32'(exc_taken), 32'h1);
        tick(); idle(); #1;
        chk("trap_exc_off", 32'(exc_taken), 32'h0);
        chk("trap_epc", EPC, 32'h0000_0100);
        chk("trap_cause", Cause, 32'h0000_0030);
        chk("trap_pc", PC_Current, 32'h0000_0180);
        load_ir({11'h0, 5'd12, 16'h0});
        #1;
        chk("trap_rd", data_out, 32'h0000_1234);

        // eret, then reset during a trap cycle
        PCWrite = 1'b1; PCSource = 3'd4;
        tick(); idle();
        chk("eret_pc", PC_Current, 32'h0000_0100);
        load_ir(ADD_INS);
        add_ovf_cycle();
        idle(); RegWrite = 1'b1; RegDst = 2'd1; MemtoReg = 2'd0; reset = 1'b1;
        #1;
        chk("rst_trap_exc", 32'(exc_taken), 32'h0);
        tick();
        reset = 1'b0; idle(); #1;
        chk("rst_trap_epc", EPC, 32'h0);
        chk("rst_trap_pc", PC_Current, 32'h0000_3000);
        chk("rst_trap_cause", Cause, 32'h0);

        // Random control sequences
        repeat (4000) begin
            reset         = ($urandom_range(0, 199) == 0);
            MIO_ready     = ($urandom_range(0, 3) != 0);
            data2CPU      = $urandom();
            IorD          = 1'($urandom_range(0, 1));
            IRWrite       = ($urandom_range(0, 3) == 0);
            RegWrite      = 1'($urandom_range(0, 1));
            RegDst        = 2'($urandom_range(0, 3));
            MemtoReg      = 2'($urandom_range(0, 3));
            ALUSrcA       = 2'($urandom_range(0, 3));
            ALUSrcB       = 2'($urandom_range(0, 3));
            Signext       = 1'($urandom_range(0, 1));
            ALU_operation = 4'($urandom_range(0, 15));
            PCWrite       = ($urandom_range(0, 3) == 0);
            PCWriteCond   = 1'($urandom_range(0, 1));
            BrCond        = 3'($urandom_range(0, 7));
            PCSource      = 3'($urandom_range(0, 7));
            OvfCheck      = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 1'b0;
        idle();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_datapath_exc.md
Name: mc_datapath_exc

Overview:
- Parametrised successor to the multicycle MIPS datapath; driven cycle-by-cycle by the existing multicycle controller FSM.
- Adds:
  - a memory ready handshake that stalls every architectural register update;
  - a 3-bit branch-condition field (beq/bne/blez/bgtz/bltz/bgez);
  - configurable reset PC and register-file depth;
  - precise arithmetic-overflow trap with EPC/Cause registers and an eret PC path.
- Sits between the controller and the MIO bus, replacing the plain datapath in the CPU top.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VEC, 32'h0000_0180, PC loaded when an overflow trap is taken.
- NREG, 32, register count (16 or 32); upper address bit ignored when 16; r0 reads 0 and ignores writes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- MIO_ready  in  1  memory/IO ready; low = stall
- data2CPU  in  32  read data from memory/IO
- IorD  in  1  0: M_addr=ALU_Out, 1: M_addr=PC_Current
- IRWrite  in  1  load Inst_R
- RegWrite  in  1  register file write enable
- RegDst  in  2  0 rt, 1 rd, 2 r31, 3 r0
- MemtoReg  in  2  0 ALU_Out, 1 MDR, 2 {imm,16'h0}, 3 PC_Current
- ALUSrcA  in  2  0 rs, 1 PC_Current, 2 MDR, 3 zero
- ALUSrcB  in  2  0 rt, 1 4, 2 imm_ext, 3 sign-extended imm<<2
- Signext  in  1  1 sign-extend imm, 0 zero-extend
- ALU_operation  in  4  existing alu opcode
- PCWrite  in  1  unconditional PC update
- PCWriteCond  in  1  conditional PC update
- BrCond  in  3  0 eq, 1 ne, 2 lez, 3 gtz, 4 ltz, 5 gez, 6-7 never
- PCSource  in  3  0 res, 1 ALU_Out, 2 jump, 3 rs, 4 EPC, 5-7 hold
- OvfCheck  in  1  current ALU op traps on overflow (add/sub/addi)
- PC_Current  out  32  program counter
- Inst_R  out  32  instruction register
- M_addr  out  32  memory address
- data_out  out  32  store data (rt)
- zero  out  1  ALU zero flag
- overflow  out  1  ALU overflow flag
- EPC  out  32  exception PC
- Cause  out  32  bit[6:2]=ExcCode (12 = Ov)
- exc_taken  out  1  one-cycle pulse when the trap is taken

Behaviour:
- Reset (sync, clk edge with reset=1): PC_Current=RESET_PC; Inst_R, MDR, ALU_Out, EPC, Cause, ovf_q=0; exc_taken=0; registers 1..NREG-1 = 0.
- Stall: when MIO_ready=0, PC, Inst_R, MDR, register writes and EPC/Cause hold. ALU_Out and ovf_q still update every cycle.
- Inst_R <= data2CPU on IRWrite&&MIO_ready. MDR <= data2CPU on MIO_ready.
- ALU_Out <= res every cycle. ovf_q <= overflow&&OvfCheck every cycle.
- Branch test uses rs value (A) and zero flag:
  - eq: zero; ne: !zero; lez: A[31]|(A==0); gtz: !A[31]&&A!=0; ltz: A[31]; gez: !A[31].
- PC update when MIO_ready and (PCWrite or (PCWriteCond and branch test true)):
  - PCSource 0: res; 1: ALU_Out; 2: {PC[31:28],Inst_R[25:0],2'b00}; 3: rs value; 4: EPC; 5-7: hold.
- Trap: a cycle with RegWrite=1, MemtoReg=0, ovf_q=1 and MIO_ready=1 is a trap cycle:
  - register write suppressed;
  - EPC <= PC_Current-4;
  - Cause[6:2] <= 12 (rest of Cause 0);
  - PC_Current <= EXC_VEC;
  - exc_taken=1 for exactly that cycle.
- Trap priority: trap overrides any simultaneous PCWrite/PCWriteCond.
- Register file: write at clk edge; read is combinational; same-cycle read of the written register returns the old value.
- Arithmetic: PC-4 wraps modulo 2^32. The lui path ignores Signext.
- Reset mid-stall or mid-trap: reset wins, and every register returns to its reset value on that edge.

Decomposition:
- Shared package holds:
  - BrCond codes (BR_EQ..BR_GEZ);
  - PCSource codes (PCS_RES, PCS_ALUOUT, PCS_JUMP, PCS_RS, PCS_EPC);
  - MemtoReg/RegDst/ALUSrc select encodings;
  - EXC_OV=5'd12.
- One sub-module: mc_regfile (NREG-parametrised register file, r0 hardwired).
- Reuse the existing alu and single_signext unchanged.

Test Plan:
- Reset with RESET_PC=32'h0000_3000 -> PC_Current=32'h3000, Inst_R=0, EPC=0, exc_taken=0 on the first cycle after reset.
- IRWrite=1, data2CPU=32'h2008_0005, MIO_ready=0 for 3 cycles then 1:
  - Inst_R holds its old value for 3 cycles and loads 32'h2008_0005 on cycle 4;
  - PCWrite with PCSource=0 advances PC by 4 only on cycle 4.
- BrCond=ne, rs=5, rt=5, PCWriteCond=1 -> PC unchanged. Repeat with rt=6 and PCSource=1, ALU_Out=32'h40 -> PC=32'h40.
- BrCond=gtz: rs=32'hFFFF_FFFF -> no branch; rs=1 -> branch taken.
- add with rs=32'h7FFF_FFFF, rt=1, OvfCheck=1, then RegWrite with MemtoReg=0 at PC=32'h104 ->
  - rd unchanged;
  - EPC=32'h100, Cause=32'h30, PC=EXC_VEC;
  - exc_taken high for one cycle.
- After the trap, PCWrite=1 with PCSource=4 -> PC=32'h100. Assert reset during a trap cycle -> EPC=0 and PC=RESET_PC.
